// File: rtl/sel_scan.sv
// sel_scan: N-channel registered selector with manual select and round-robin auto-scan.
// Optional per-channel ch_mask when SEL_SCAN_MASK_EN is defined.
module sel_scan #(
   parameter  int NCH  = 8,
   parameter  int W    = 4,
   parameter  int DIV  = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [NCH*W-1:0]  in,
   input  logic [SELW-1:0]   sel,
`ifdef SEL_SCAN_MASK_EN
   input  logic [NCH-1:0]    ch_mask,
`endif
   output logic [W-1:0]      out,
   output logic [SELW-1:0]   ch,
   output logic              out_valid,
   output logic              wrap
);

   localparam int CW = $clog2(DIV) + 1;

   typedef enum logic [1:0] {
      OFF,
      MAN,
      SCAN
   } st_e;

   st_e               st;
   logic [CW-1:0]     cnt;
   logic [W-1:0]      chans [NCH];
   logic [NCH-1:0]    m;
   logic [SELW-1:0]   nxt;
   logic              nwrap;
   logic              sel_bad;
   logic [SELW:0]     sum;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign chans[k] = in[k*W +: W];
   end

`ifdef SEL_SCAN_MASK_EN
   assign m = ch_mask;
`else
   assign m = '1;
`endif

   assign sel_bad = {1'b0, sel} >= (SELW+1)'(NCH);

   always_comb begin
      st = SCAN;
      if (!en)
         st = OFF;
      else if (!mode)
         st = MAN;
   end

   // Circular search from ch+1; walking k downward lets the nearest hit win.
   always_comb begin
      nxt   = ch;
      nwrap = 1'b0;
      sum   = '0;
      for (int k = NCH; k >= 1; k--) begin
         sum = {1'b0, ch} + (SELW+1)'(k);
         if (sum >= (SELW+1)'(NCH)) begin
            sum = sum - (SELW+1)'(NCH);
            if (m[sum[SELW-1:0]]) begin
               nxt   = sum[SELW-1:0];
               nwrap = 1'b1;
            end
         end else if (m[sum[SELW-1:0]]) begin
            nxt   = sum[SELW-1:0];
            nwrap = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         ch        <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         cnt       <= '0;
      end else begin
         wrap <= 1'b0;
         case (st)
            OFF: begin
               out       <= '0;
               out_valid <= 1'b0;
               cnt       <= '0;
            end
            MAN: begin
               cnt <= '0;
               if (sel_bad) begin
                  out       <= '0;
                  out_valid <= 1'b0;
               end else begin
                  ch        <= sel;
                  out       <= m[sel] ? chans[sel] : '0;
                  out_valid <= m[sel];
               end
            end
            default: begin
               if (!(|m)) begin
                  out       <= '0;
                  out_valid <= 1'b0;
                  cnt       <= '0;
               end else if (cnt == CW'(DIV-1)) begin
                  cnt       <= '0;
                  ch        <= nxt;
                  out       <= chans[nxt];
                  out_valid <= 1'b1;
                  wrap      <= nwrap;
               end else begin
                  cnt       <= cnt + 1'b1;
                  out       <= m[ch] ? chans[ch] : '0;
                  out_valid <= m[ch];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sel_scan.sv
// tb_sel_scan: scoreboard bench for sel_scan (8ch/DIV4, 8ch/DIV1, 5ch/DIV4).
// Mask scenarios are built in when SEL_SCAN_MASK_EN is defined.
module tb_sel_scan;

   typedef struct {
      int ch;
      int out;
      bit valid;
      bit wrap;
      int cnt;
   } st_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] din = '0;
   logic [2:0]  sel = '0;
   logic [7:0]  mask = 8'hFF;

   logic [3:0] d8_out, d1_out, d5_out;
   logic [2:0] d8_ch, d1_ch, d5_ch;
   logic       d8_v, d1_v, d5_v;
   logic       d8_w, d1_w, d5_w;

   int checks = 0;
   int errors = 0;

   st_t m8, m1, m5;
   st_t q8[$], q1[$], q5[$];

   always #5 clk = ~clk;

   sel_scan #(.NCH(8), .W(4), .DIV(4)) dut8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in(din), .sel(sel),
`ifdef SEL_SCAN_MASK_EN
      .ch_mask(mask),
`endif
      .out(d8_out), .ch(d8_ch), .out_valid(d8_v), .wrap(d8_w));

   sel_scan #(.NCH(8), .W(4), .DIV(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in(din), .sel(sel),
`ifdef SEL_SCAN_MASK_EN
      .ch_mask(mask),
`endif
      .out(d1_out), .ch(d1_ch), .out_valid(d1_v), .wrap(d1_w));

   sel_scan #(.NCH(5), .W(4), .DIV(4)) dut5 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in(din[19:0]), .sel(sel),
`ifdef SEL_SCAN_MASK_EN
      .ch_mask(mask[4:0]),
`endif
      .out(d5_out), .ch(d5_ch), .out_valid(d5_v), .wrap(d5_w));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic st_t mstep(st_t s, int nch, int div);
      st_t n;
      logic [7:0] msk;
      int c;
      n = s;
      n.wrap = 0;
      msk = mask & 8'((1 << nch) - 1);
      if (rst) begin
         n.ch = 0; n.out = 0; n.valid = 0; n.cnt = 0;
      end else if (!en) begin
         n.out = 0; n.valid = 0; n.cnt = 0;
      end else if (!mode) begin
         n.cnt = 0;
         if (int'(sel) >= nch) begin
            n.out = 0; n.valid = 0;
         end else begin
            n.ch = int'(sel);
            n.valid = msk[sel];
            n.out = n.valid ? int'(din[int'(sel)*4 +: 4]) : 0;
         end
      end else if (msk == 0) begin
         n.out = 0; n.valid = 0; n.cnt = 0;
      end else if (s.cnt == div - 1) begin
         n.cnt = 0;
         for (int k = 1; k <= nch; k++) begin
            c = (s.ch + k) % nch;
            if (msk[c]) begin
               n.ch = c;
               n.wrap = (s.ch + k >= nch);
               break;
            end
         end
         n.out = int'(din[n.ch*4 +: 4]);
         n.valid = 1;
      end else begin
         n.cnt = s.cnt + 1;
         n.valid = msk[s.ch];
         n.out = n.valid ? int'(din[s.ch*4 +: 4]) : 0;
      end
      return n;
   endfunction

   task automatic cmp(input string p, input st_t e, input logic [31:0] c,
                      input logic [31:0] o, input logic [31:0] v,
                      input logic [31:0] w);
      check({p, ".ch"}, c, e.ch);
      check({p, ".out"}, o, e.out);
      check({p, ".valid"}, v, 32'(e.valid));
      check({p, ".wrap"}, w, 32'(e.wrap));
   endtask

   task automatic tick();
      st_t e;
      m8 = mstep(m8, 8, 4); q8.push_back(m8);
      m1 = mstep(m1, 8, 1); q1.push_back(m1);
      m5 = mstep(m5, 5, 4); q5.push_back(m5);
      @(posedge clk);
      #1;
      e = q8.pop_front(); cmp("d8", e, d8_ch, d8_out, d8_v, d8_w);
      e = q1.pop_front(); cmp("d1", e, d1_ch, d1_out, d1_v, d1_w);
      e = q5.pop_front(); cmp("d5", e, d5_ch, d5_out, d5_v, d5_w);
   endtask

   task automatic run_to_ch(input int target, input string tag);
      int n = 0;
      while (int'(d8_ch) != target && n < 80) begin
         tick();
         n++;
      end
      check(tag, d8_ch, target);
   endtask

   initial begin
      int w8, w1;
      m8 = '{0, 0, 0, 0, 0};
      m1 = '{0, 0, 0, 0, 0};
      m5 = '{0, 0, 0, 0, 0};

      rst = 1'b1;
      din = $urandom;
      tick();
      din = $urandom;
      tick();
      check("rst.out", d8_out, 0);
      check("rst.ch", d8_ch, 0);
      check("rst.valid", d8_v, 0);
      check("rst.wrap", d8_w, 0);
      rst = 1'b0;
      en = 1'b0;
      repeat (3) tick();

      din = 32'h76543210;
      en = 1'b1;
      mode = 1'b0;
      sel = 3'd5;
      tick();
      check("man.out5", d8_out, 4'h5);
      check("man.ch5", d8_ch, 5);
      check("man.valid", d8_v, 1);
      sel = 3'd2;
      tick();
      check("man.out2", d8_out, 4'h2);

      sel = 3'd0;
      tick();
      mode = 1'b1;
      w8 = 0;
      w1 = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         w8 += int'(d8_w);
         w1 += int'(d1_w);
         if (i == 3) check("scan.step1", d8_ch, 1);
      end
      check("scan.lap_wraps", w8, 1);
      check("scan.ch_after_lap", d8_ch, 0);
      check("div1.lap_wraps", w1, 4);

      run_to_ch(1, "scan.reach1");
      din[7:4] = 4'hA;
      tick();
      check("scan.live_in", d8_out, 4'hA);

      run_to_ch(6, "scan.reach6");
      rst = 1'b1;
      tick();
      check("midrst.ch", d8_ch, 0);
      check("midrst.out", d8_out, 0);
      rst = 1'b0;

      run_to_ch(3, "scan.reach3");
      en = 1'b0;
      repeat (10) tick();
      check("off.ch_held", d8_ch, 3);
      en = 1'b1;
      repeat (3) tick();
      check("resume.hold3", d8_ch, 3);
      tick();
      check("resume.adv4", d8_ch, 4);

      mode = 1'b0;
      sel = 3'd2;
      tick();
      sel = 3'd6;
      tick();
      check("n5.bad_valid", d5_v, 0);
      check("n5.bad_out", d5_out, 0);
      check("n5.bad_ch", d5_ch, 2);

`ifdef SEL_SCAN_MASK_EN
      mask = 8'b1000_0101;
      sel = 3'd0;
      tick();
      mode = 1'b1;
      repeat (4) tick();
      check("mask.ch2", d8_ch, 2);
      repeat (4) tick();
      check("mask.ch7", d8_ch, 7);
      repeat (4) tick();
      check("mask.ch0", d8_ch, 0);
      check("mask.wrap", d8_w, 1);
      mask = 8'h00;
      repeat (3) tick();
      check("mask0.valid", d8_v, 0);
      check("mask0.ch", d8_ch, 0);
      mask = 8'b1000_0101;
      mode = 1'b0;
      sel = 3'd1;
      tick();
      check("mask.man_ch", d8_ch, 1);
      check("mask.man_valid", d8_v, 0);
      check("mask.man_out", d8_out, 0);
`endif

      for (int i = 0; i < 200; i++) begin
         rst = ($urandom_range(0, 29) == 0);
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) din = $urandom;
`ifdef SEL_SCAN_MASK_EN
         if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
`endif
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
